// File: rtl/fifo_rr_drain.sv
// Round-robin drain of a bank of first-word-fall-through FIFOs into a single
// valid/ready stream, granting one FIFO per burst of up to BURST_LEN beats.
module fifo_rr_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_FIFOS   = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int BURST_LEN   = 4,
    parameter int BURST_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable_i,
    input  logic [NUM_FIFOS-1:0]            mask_i,
    input  logic [NUM_FIFOS-1:0]            fifo_empty_i,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_dout_i,
    output logic [NUM_FIFOS-1:0]            fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0]           dout_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [SEL_WIDTH-1:0]            sel_o,
    output logic                            last_o,
    output logic                            busy_o
);

    localparam int NUM_SLOTS = 1 << SEL_WIDTH;
    localparam int SUM_WIDTH = SEL_WIDTH + 1;
    localparam logic [BURST_WIDTH-1:0] LAST_COUNT = BURST_WIDTH'(BURST_LEN - 1);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [SEL_WIDTH-1:0]   ptr_reg;
    logic [SEL_WIDTH-1:0]   ptr_next;
    logic [SEL_WIDTH-1:0]   sel_reg;
    logic [SEL_WIDTH-1:0]   sel_next;
    logic [BURST_WIDTH-1:0] count_reg;
    logic [BURST_WIDTH-1:0] count_next;

    logic [NUM_SLOTS-1:0]   req;
    logic [NUM_SLOTS-1:0]   empty_ext;
    logic [DATA_WIDTH-1:0]  words [NUM_SLOTS];
    logic                   grant_found;
    logic [SEL_WIDTH-1:0]   grant_idx;
    logic                   sel_empty;
    logic                   transfer;
    logic                   at_last;

    // Pad the per-FIFO vectors to the full sel_o range so indexing by sel is
    // always in bounds; unused slots look permanently empty.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi < NUM_FIFOS) begin : g_real
                assign words[gi]     = fifo_dout_i[gi*DATA_WIDTH +: DATA_WIDTH];
                assign empty_ext[gi] = fifo_empty_i[gi];
                assign req[gi]       = ~fifo_empty_i[gi] & mask_i[gi];
            end else begin : g_pad
                assign words[gi]     = '0;
                assign empty_ext[gi] = 1'b1;
                assign req[gi]       = 1'b0;
            end
        end
    endgenerate

    assign sel_empty = empty_ext[sel_reg];
    assign at_last   = (count_reg == LAST_COUNT);
    assign transfer  = (state_reg == GRANT) & ~sel_empty & ready_i;

    // Walk offsets from the far end back to ptr+1 so the nearest requester
    // after the last grant is the one left standing.
    always_comb begin
        logic [SUM_WIDTH-1:0] sum;
        sum         = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = NUM_FIFOS; off >= 1; off--) begin
            sum = {1'b0, ptr_reg} + SUM_WIDTH'(off);
            if (sum >= SUM_WIDTH'(NUM_FIFOS)) begin
                sum = sum - SUM_WIDTH'(NUM_FIFOS);
            end
            if (req[sum[SEL_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[SEL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= SEL_WIDTH'(NUM_FIFOS - 1);
            sel_reg   <= '0;
            count_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        count_next = count_reg;
        case (state_reg)
            ARB: begin
                if (enable_i && grant_found) begin
                    state_next = GRANT;
                    sel_next   = grant_idx;
                    count_next = '0;
                end
            end
            GRANT: begin
                if (sel_empty) begin
                    state_next = ARB;
                    ptr_next   = sel_reg;
                end else if (transfer) begin
                    if (at_last) begin
                        state_next = ARB;
                        ptr_next   = sel_reg;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    always_comb begin
        busy_o  = (state_reg == GRANT);
        valid_o = (state_reg == GRANT) & ~sel_empty;
        last_o  = (state_reg == GRANT) & at_last;
        dout_o  = words[sel_reg];
        sel_o   = sel_reg;
    end

    generate
        for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_rd_en
            assign fifo_rd_en_o[gi] = transfer & (sel_reg == SEL_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: behavioural FWFT FIFO bank plus
// hand-derived expectations for each scenario.
module tb_fifo_rr_drain;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable_i = 1'b1;
    logic [3:0]   mask_i = 4'hF;
    logic [3:0]   fifo_empty;
    logic [127:0] fifo_dout;
    logic [3:0]   fifo_rd_en_o;
    logic [31:0]  dout_o;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [1:0]   sel_o;
    logic         last_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    int head [4] = '{0, 0, 0, 0};
    int tail [4] = '{0, 0, 0, 0};
    int base [4] = '{0, 0, 0, 0};
    int nb   [4];

    always #5 clk = ~clk;

    fifo_rr_drain dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .mask_i       (mask_i),
        .fifo_empty_i (fifo_empty),
        .fifo_dout_i  (fifo_dout),
        .fifo_rd_en_o (fifo_rd_en_o),
        .dout_o       (dout_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .sel_o        (sel_o),
        .last_o       (last_o),
        .busy_o       (busy_o)
    );

    function automatic logic [31:0] word(input int i, input int idx);
        return 32'hD000_0000 + 32'(i * 4096) + 32'(idx);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]        = (head[i] >= tail[i]);
            fifo_dout[i*32 +: 32] = word(i, head[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_en_o[i] && head[i] < tail[i]) head[i] <= head[i] + 1;
        end
    end

    // Reset, empty the bank, load n words into each FIFO in load_mask, release.
    task automatic apply_reset(input logic [3:0] load_mask, input int n);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tail[i] = head[i];
            base[i] = head[i];
            nb[i]   = 0;
            if (load_mask[i]) tail[i] = tail[i] + n;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if (fifo_rd_en_o !== 4'h0) begin errors++; $display("FAIL reset_rd_en got=%h exp=0", fifo_rd_en_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%0b exp=0", last_o); end
        checks++; if (sel_o !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel_o); end
        checks++; if (dout_o !== word(0, 0)) begin errors++; $display("FAIL reset_dout got=%h exp=%h", dout_o, word(0, 0)); end
        $display("test_reset: valid=%0b busy=%0b sel=%0d", valid_o, busy_o, sel_o);
    endtask

    task automatic test_round_robin;
        int g;
        int ph;
        int s;
        apply_reset(4'hF, 8);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            g  = j / 5;
            ph = j % 5;
            s  = g % 4;
            if (ph == 4) begin
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rr_arb_valid j=%0d got=%0b exp=0", j, valid_o); end
                checks++; if (fifo_rd_en_o !== 4'h0) begin errors++; $display("FAIL rr_arb_rd_en j=%0d got=%h exp=0", j, fifo_rd_en_o); end
            end else begin
                checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rr_valid j=%0d got=%0b exp=1", j, valid_o); end
                checks++; if (sel_o !== 2'(s)) begin errors++; $display("FAIL rr_sel j=%0d got=%0d exp=%0d", j, sel_o, s); end
                checks++; if (dout_o !== word(s, base[s] + (g / 4) * 4 + ph)) begin
                    errors++; $display("FAIL rr_dout j=%0d got=%h exp=%h", j, dout_o, word(s, base[s] + (g / 4) * 4 + ph)); end
                checks++; if (fifo_rd_en_o !== 4'(1 << s)) begin errors++; $display("FAIL rr_rd_en j=%0d got=%h exp=%h", j, fifo_rd_en_o, 4'(1 << s)); end
                checks++; if (last_o !== (ph == 3)) begin errors++; $display("FAIL rr_last j=%0d got=%0b exp=%0b", j, last_o, ph == 3); end
            end
            $display("rr j=%0d valid=%0b sel=%0d dout=%h last=%0b", j, valid_o, sel_o, dout_o, last_o);
        end
    endtask

    task automatic test_single_short;
        apply_reset(4'b0100, 3);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j < 3) begin
                checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL short_valid j=%0d got=%0b exp=1", j, valid_o); end
                checks++; if (sel_o !== 2'd2) begin errors++; $display("FAIL short_sel j=%0d got=%0d exp=2", j, sel_o); end
                checks++; if (dout_o !== word(2, base[2] + j)) begin errors++; $display("FAIL short_dout j=%0d got=%h exp=%h", j, dout_o, word(2, base[2] + j)); end
                checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL short_last j=%0d got=%0b exp=0", j, last_o); end
            end else begin
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL short_end_valid j=%0d got=%0b exp=0", j, valid_o); end
                checks++; if (busy_o !== (j == 3)) begin errors++; $display("FAIL short_busy j=%0d got=%0b exp=%0b", j, busy_o, j == 3); end
            end
            $display("short j=%0d valid=%0b busy=%0b sel=%0d dout=%h", j, valid_o, busy_o, sel_o, dout_o);
        end
    endtask

    task automatic test_backpressure;
        int beats;
        beats = 0;
        apply_reset(4'b0010, 4);
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            ready_i = (j % 3 == 0);
            #1;
            if (j < 10) begin
                checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid j=%0d got=%0b exp=1", j, valid_o); end
                checks++; if (dout_o !== word(1, base[1] + beats)) begin errors++; $display("FAIL bp_dout j=%0d got=%h exp=%h", j, dout_o, word(1, base[1] + beats)); end
                checks++; if (fifo_rd_en_o !== (ready_i ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL bp_rd_en j=%0d got=%h ready=%0b", j, fifo_rd_en_o, ready_i); end
                checks++; if (last_o !== (beats == 3)) begin errors++; $display("FAIL bp_last j=%0d got=%0b exp=%0b", j, last_o, beats == 3); end
                if (ready_i) beats++;
            end else begin
                checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL bp_end j=%0d valid=%0b busy=%0b exp=0/0", j, valid_o, busy_o); end
                checks++; if (beats != 4 || head[1] != base[1] + 4) begin errors++; $display("FAIL bp_count beats=%0d popped=%0d exp=4", beats, head[1] - base[1]); end
            end
            $display("bp j=%0d ready=%0b valid=%0b dout=%h rd_en=%h", j, ready_i, valid_o, dout_o, fifo_rd_en_o);
        end
        ready_i = 1'b1;
    endtask

    task automatic test_mask;
        int order [5] = '{1, 3, 1, 3, 3};
        int s;
        apply_reset(4'hF, 12);
        mask_i = 4'b1010;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            s = order[j / 5];
            if (j % 5 == 4) begin
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mask_arb_valid j=%0d got=%0b exp=0", j, valid_o); end
            end else begin
                checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mask_valid j=%0d got=%0b exp=1", j, valid_o); end
                checks++; if (sel_o !== 2'(s)) begin errors++; $display("FAIL mask_sel j=%0d got=%0d exp=%0d", j, sel_o, s); end
                checks++; if (dout_o !== word(s, base[s] + nb[s])) begin errors++; $display("FAIL mask_dout j=%0d got=%h exp=%h", j, dout_o, word(s, base[s] + nb[s])); end
                nb[s]++;
            end
            $display("mask j=%0d mask=%b valid=%0b sel=%0d dout=%h", j, mask_i, valid_o, sel_o, dout_o);
            if (j == 11) mask_i = 4'b1000;
        end
        mask_i = 4'hF;
    endtask

    task automatic test_enable;
        enable_i = 1'b0;
        apply_reset(4'b0101, 4);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL enable_off j=%0d valid=%0b busy=%0b exp=0/0", j, valid_o, busy_o); end
            $display("enable_off j=%0d valid=%0b busy=%0b", j, valid_o, busy_o);
        end
        enable_i = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL enable_on valid=%0b busy=%0b exp=1/1", valid_o, busy_o); end
        checks++; if (sel_o !== 2'd0) begin errors++; $display("FAIL enable_sel got=%0d exp=0", sel_o); end
        $display("enable_on valid=%0b busy=%0b sel=%0d", valid_o, busy_o, sel_o);
    endtask

    task automatic test_reset_midburst;
        apply_reset(4'hF, 8);
        // Grant 0 runs j=0..3, ARB at j=4, grant 1 beat 1 at j=5, beat 2 at j=6.
        for (int j = 0; j < 7; j++) @(negedge clk);
        checks++; if (valid_o !== 1'b1 || sel_o !== 2'd1) begin errors++; $display("FAIL mid_pre valid=%0b sel=%0d exp=1/1", valid_o, sel_o); end
        #1 rst = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_async valid=%0b busy=%0b exp=0/0", valid_o, busy_o); end
        checks++; if (fifo_rd_en_o !== 4'h0 || sel_o !== 2'd0) begin errors++; $display("FAIL mid_rd_sel rd_en=%h sel=%0d exp=0/0", fifo_rd_en_o, sel_o); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (head[1] != base[1] + 1) begin errors++; $display("FAIL mid_popped got=%0d exp=1", head[1] - base[1]); end
        @(negedge clk);
        checks++; if (sel_o !== 2'd0 || valid_o !== 1'b1) begin errors++; $display("FAIL mid_regrant sel=%0d valid=%0b exp=0/1", sel_o, valid_o); end
        checks++; if (dout_o !== word(0, base[0] + 4)) begin errors++; $display("FAIL mid_dout got=%h exp=%h", dout_o, word(0, base[0] + 4)); end
        $display("midburst regrant sel=%0d valid=%0b dout=%h", sel_o, valid_o, dout_o);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_short();
        test_backpressure();
        test_mask();
        test_enable();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
